// File: rtl/letter_spawner.sv
// rtl/letter_spawner.sv - paced pseudo-random falling-letter spawner with valid/ready output
module letter_spawner #(
  parameter int          LANES          = 70,
  parameter int          LANE_PITCH     = 9,
  parameter int          MAX_SPEED      = 4,
  parameter int          SPAWN_INTERVAL = 25_000_000,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [1:0]  level,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  ch,
  output logic [2:0]  speed,
  output logic [8:0]  x,
  output logic [9:0]  y,
  output logic [15:0] spawn_count
);

  localparam int          TW         = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SPAWN_INTERVAL - 1);
  // An all-zero Galois state would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  // LANES is never a legal lane index, so it marks "no previous lane".
  localparam logic [7:0]  NO_LANE    = 8'(LANES);

  typedef enum logic [1:0] {IDLE, WAIT, DRAW, HOLD} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [15:0]     lfsr;
  logic [7:0]      last_lane;
  logic [7:0]      lane_q;

  logic [7:0]      lane_raw;
  logic [7:0]      lane_next;
  logic [5:0]      idx;
  logic [7:0]      ch_next;
  logic [3:0]      speed_base;
  logic [3:0]      speed_sum;
  logic [2:0]      speed_next;
  logic [9:0]      y_next;

  // Spawn row is fixed at the top of the playfield.
  assign x = 9'd0;

  // Free-running Galois LFSR; keeps stepping even while the game is paused.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Lane pick with a one-step bump so the same lane never fires twice in a row.
  always_comb begin
    lane_raw  = 8'(32'(lfsr[7:0]) % LANES);
    lane_next = lane_raw;
    if (lane_raw == last_lane) begin
      lane_next = ((32'(lane_raw) + 1) == LANES) ? 8'd0 : lane_raw + 8'd1;
    end
    y_next = 10'(32'(lane_next) * LANE_PITCH);
  end

  // Character selection from the upper LFSR byte within the chosen symbol set.
  always_comb begin
    case (mode)
      2'd2:    idx = 6'(32'(lfsr[15:8]) % 10);
      2'd3:    idx = 6'(32'(lfsr[15:8]) % 36);
      default: idx = 6'(32'(lfsr[15:8]) % 26);
    endcase
    case (mode)
      2'd0:    ch_next = 8'd65 + {2'b00, idx};
      2'd1:    ch_next = 8'd97 + {2'b00, idx};
      2'd2:    ch_next = 8'd48 + {2'b00, idx};
      default: ch_next = (idx < 6'd26) ? (8'd65 + {2'b00, idx})
                                       : (8'd48 + {2'b00, idx} - 8'd26);
    endcase
  end

  // Speed is a random base plus the difficulty offset, clamped to the 3-bit range.
  always_comb begin
    speed_base = 4'(32'(lfsr[11:8] ^ lfsr[3:0]) % MAX_SPEED) + 4'd1;
    speed_sum  = speed_base + {2'b00, level};
    speed_next = (speed_sum > 4'd7) ? 3'd7 : speed_sum[2:0];
  end

  // Spawn pacing FSM with registered handshake outputs and held fields.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      timer       <= '0;
      last_lane   <= NO_LANE;
      lane_q      <= 8'd0;
      out_valid   <= 1'b0;
      ch          <= 8'd65;
      speed       <= 3'd1;
      y           <= 10'd0;
      spawn_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (enable) state <= WAIT;
        end
        WAIT: begin
          if (!enable) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == TIMER_LAST) begin
            state <= DRAW;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DRAW: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            lane_q    <= lane_next;
            ch        <= ch_next;
            speed     <= speed_next;
            y         <= y_next;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // The offer stands until taken, even if the game is paused meanwhile.
          if (out_ready) begin
            out_valid   <= 1'b0;
            spawn_count <= spawn_count + 16'd1;
            last_lane   <= lane_q;
            timer       <= '0;
            state       <= enable ? WAIT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_letter_spawner.sv
// tb/tb_letter_spawner.sv - scoreboard bench for letter_spawner
module tb_letter_spawner;

  localparam int          SI      = 4;
  localparam int          LANES_P = 70;
  localparam int          PITCH   = 9;
  localparam int          MAXS    = 4;
  localparam logic [15:0] SEED_P  = 16'hACE1;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [1:0]  level = 2'd0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  ch;
  logic [2:0]  speed;
  logic [8:0]  x;
  logic [9:0]  y;
  logic [15:0] spawn_count;

  always #5 clk = ~clk;

  letter_spawner #(
    .LANES(LANES_P),
    .LANE_PITCH(PITCH),
    .MAX_SPEED(MAXS),
    .SPAWN_INTERVAL(SI),
    .SEED(SEED_P)
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .enable(enable),
    .mode(mode),
    .level(level),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .ch(ch),
    .speed(speed),
    .x(x),
    .y(y),
    .spawn_count(spawn_count)
  );

  typedef struct {
    int ch;
    int speed;
    int y;
    int draw_edge;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          ecount = 0;
  logic [15:0] m_lfsr;
  int          m_last_lane = LANES_P;
  int          next_draw = 0;
  int          mon_count = 0;
  int          prev_y = -1;
  bit          mon_prev_valid = 1'b0;
  bit          phase3 = 1'b0;
  bit          saw_s7 = 1'b0;
  bit          saw_digit = 1'b0;
  bit          saw_upper = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at edge %0d", name, act, req, ecount);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge clk) ecount++;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) m_lfsr <= SEED_P;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  // Monitor: compares whatever the DUT offers against the scoreboard head.
  always @(negedge clk) begin
    if (!clrn) begin
      mon_prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          if (!mon_prev_valid) begin
            check("valid_rise_edge", ecount, sb[0].draw_edge);
            check("y_pitch", int'(y) % PITCH, 0);
            check("y_max", int'(y) <= 621, 1);
            check("y_repeat", int'(y) == prev_y, 0);
            prev_y = int'(y);
            if (phase3 && ch >= 8'd48 && ch <= 8'd57) saw_digit = 1'b1;
            if (phase3 && ch >= 8'd65 && ch <= 8'd90) saw_upper = 1'b1;
            if (speed == 3'd7) saw_s7 = 1'b1;
          end
          check("ch", int'(ch), sb[0].ch);
          check("speed", int'(speed), sb[0].speed);
          check("y", int'(y), sb[0].y);
          check("x", int'(x), 0);
          check("count_held", int'(spawn_count), mon_count % 65536);
        end
      end else if (mon_prev_valid && sb.size() > 0) begin
        e = sb.pop_front();
        mon_count++;
        check("spawn_count", int'(spawn_count), mon_count % 65536);
      end
      mon_prev_valid = out_valid;
    end
  end

  task automatic wait_edge(input int t);
    while (ecount < t) @(negedge clk);
  endtask

  task automatic push_expected();
    int   lr, lane, span, idx, c, s;
    exp_t n;
    lr   = int'(m_lfsr[7:0]) % LANES_P;
    lane = (lr == m_last_lane) ? (lr + 1) % LANES_P : lr;
    span = (mode == 2'd2) ? 10 : (mode == 2'd3) ? 36 : 26;
    idx  = int'(m_lfsr[15:8]) % span;
    case (mode)
      2'd0:    c = 65 + idx;
      2'd1:    c = 97 + idx;
      2'd2:    c = 48 + idx;
      default: c = (idx < 26) ? 65 + idx : 48 + idx - 26;
    endcase
    s = (int'(m_lfsr[11:8] ^ m_lfsr[3:0]) % MAXS) + 1 + int'(level);
    if (s > 7) s = 7;
    n.ch = c;
    n.speed = s;
    n.y = lane * PITCH;
    n.draw_edge = next_draw;
    sb.push_back(n);
    m_last_lane = lane;
  endtask

  // One spawn: predict it just before its DRAW edge, optionally stall the consumer.
  task automatic spawn_one(input int stall);
    int         d;
    logic [1:0] sm, sl;
    d = next_draw;
    wait_edge(d - 1);
    out_ready = (stall == 0);
    push_expected();
    wait_edge(d);
    if (stall == 0) begin
      next_draw = d + SI + 2;
    end else begin
      sm = mode;
      sl = level;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        mode  = mode + 2'd1;
        level = level + 2'd1;
      end
      mode      = sm;
      level     = sl;
      out_ready = 1'b1;
      next_draw = ecount + SI + 2;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_ch", int'(ch), 65);
    check("rst_speed", int'(speed), 1);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_count", int'(spawn_count), 0);
    clrn = 1'b1;
    repeat (3) @(negedge clk);

    // Continuous acceptance: valid every SI+2 cycles from enable.
    out_ready = 1'b1;
    enable = 1'b1;
    next_draw = ecount + 1 + SI + 1;
    repeat (3) spawn_one(0);
    wait_edge(next_draw - SI - 1);
    check("count_after_three", int'(spawn_count), 3);
    repeat (97) spawn_one(0);
    mode = 2'd1; level = 2'd1;
    repeat (100) spawn_one(0);
    mode = 2'd2; level = 2'd2;
    repeat (500) spawn_one(0);
    mode = 2'd3; level = 2'd3; phase3 = 1'b1;
    repeat (300) spawn_one(0);
    phase3 = 1'b0;

    // Back-pressure with mode/level churn while held.
    mode = 2'd0; level = 2'd0;
    spawn_one(100);
    wait_edge(next_draw - SI);
    check("count_after_stall", int'(spawn_count), 1001);

    // Pause during WAIT: nothing may be offered.
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("paused_valid", int'(out_valid), 0);
    check("paused_count", int'(spawn_count), 1001);
    enable = 1'b1;
    next_draw = ecount + 1 + SI + 1;
    repeat (2) spawn_one(0);

    // Reset while an offer is held.
    wait_edge(next_draw - 1);
    out_ready = 1'b0;
    push_expected();
    wait_edge(next_draw);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    check("hold_rst_valid", int'(out_valid), 0);
    check("hold_rst_ch", int'(ch), 65);
    check("hold_rst_speed", int'(speed), 1);
    check("hold_rst_y", int'(y), 0);
    check("hold_rst_count", int'(spawn_count), 0);
    sb.delete();
    mon_count = 0;
    prev_y = -1;
    m_last_lane = LANES_P;
    enable = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    next_draw = ecount + 1 + SI + 1;
    repeat (3) spawn_one(0);
    wait_edge(next_draw - SI - 1);
    check("count_after_reset", int'(spawn_count), 3);

    check("saw_speed7", int'(saw_s7), 1);
    check("mode3_digit", int'(saw_digit), 1);
    check("mode3_upper", int'(saw_upper), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/letter_spawner.md
# letter_spawner

Parametrised successor to the falling-letter generator in the typing game. It paces letter spawns with an internal interval timer and draws character, lane and speed from its own 16-bit LFSR. Each spawn is offered to the sprite manager over a valid/ready handshake and held stable until accepted. Compared with the earlier generator it adds selectable character sets, a difficulty speed offset, no-repeat lanes, back-pressure and a spawn counter.

## Interface
- `LANES`, default 70: number of horizontal lanes. Legal range 2..255.
- `LANE_PITCH`, default 9: pixels between lanes. `LANES*LANE_PITCH` must be ≤ 1024.
- `MAX_SPEED`, default 4: base speed range, 1..MAX_SPEED. Legal range 1..7.
- `SPAWN_INTERVAL`, default 25_000_000: clk cycles counted in WAIT. Must be ≥ 1.
- `SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- `clk`, in, 1: system clock.
- `clrn`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: game running.
- `mode`, in, 2: character set. 0 = 'A'-'Z', 1 = 'a'-'z', 2 = '0'-'9', 3 = 'A'-'Z' plus '0'-'9' (36 symbols).
- `level`, in, 2: speed offset added to the base speed.
- `out_ready`, in, 1: consumer accepts the current spawn.
- `out_valid`, out, 1: spawn fields are valid.
- `ch`, out, 8: ASCII code.
- `speed`, out, 3: pixels per frame tick.
- `x`, out, 9: spawn row, always 0.
- `y`, out, 10: spawn column pixel, equal to lane*LANE_PITCH.
- `spawn_count`, out, 16: number of accepted spawns, wraps.

## Operation
- LFSR: 16-bit Galois, mask 16'hB400. It advances every clk cycle while `clrn` is high, independent of `enable`.
- FSM states: IDLE, WAIT, DRAW, HOLD.
  - IDLE: timer = 0. If `enable`=1, go to WAIT.
  - WAIT: timer increments each cycle. If `enable`=0, go to IDLE. When timer = SPAWN_INTERVAL-1, go to DRAW.
  - DRAW: one cycle. Register the fields below from the current LFSR value (L), then go to HOLD. If `enable`=0, go to IDLE instead and register nothing.
  - HOLD: `out_valid`=1 and all fields are frozen. When `out_ready`=1, the handshake completes: `spawn_count`+1, last_lane ← lane, and timer cleared. Next state is WAIT if `enable`=1, otherwise IDLE. Dropping `enable` in HOLD does not withdraw the offer.
- Field derivation in DRAW:
  - lane = L[7:0] % LANES. If lane == last_lane, lane = (lane+1) % LANES.
  - idx = L[15:8] % span, where span is 26/26/10/36 for mode 0/1/2/3.
  - ch: mode 0 gives 65+idx. Mode 1 gives 97+idx. Mode 2 gives 48+idx. Mode 3 gives 65+idx for idx<26, otherwise 48+(idx-26).
  - speed = ((L[11:8] ^ L[3:0]) % MAX_SPEED) + 1 + level, saturated at 7.
  - y = lane*LANE_PITCH, computed at full width and then truncated to 10 bits. The parameter rule guarantees no loss.
- `mode` and `level` are sampled only in DRAW. Changes while in HOLD do not alter the held spawn.
- last_lane resets to the value LANES, meaning no previous lane, so the first spawn is never adjusted.

## Timing
- Reset values:
  - `out_valid` 0, `ch` 8'd65, `speed` 3'd1, `x` 0, `y` 0, `spawn_count` 0.
  - State IDLE, timer 0, LFSR = SEED.
- Latency:
  - `enable` is sampled high at edge n. WAIT is entered at n+1.
  - DRAW occurs at n+SPAWN_INTERVAL+1.
  - `out_valid` first rises at n+SPAWN_INTERVAL+2.
- Throughput: if `out_ready` is held at 1, one spawn every SPAWN_INTERVAL+2 cycles.
- Handshake: the transfer happens on an edge where `out_valid` & `out_ready` are both 1. `out_valid` falls the following cycle. Outputs never change while `out_valid`=1 and `out_ready`=0.
- `spawn_count` wraps from 16'hFFFF to 0.
- Reset mid-HOLD: `out_valid` drops immediately (asynchronous) and the spawn is lost. `spawn_count` is not incremented.

## Test plan
- SPAWN_INTERVAL=4, `enable` rises at cycle 10, `out_ready`=1 → `out_valid` pulses at cycles 16, 22, 28, … and `spawn_count` = 3 after the third pulse.
- `mode`=2 over 500 spawns → every `ch` in 48..57. `mode`=3 → `ch` in 48..57 ∪ 65..90, with both ranges hit. `x`=0 throughout.
- MAX_SPEED=4, `level`=3 → `speed` in 4..7 with 7 reached. `level`=0 → `speed` in 1..4.
- `out_ready`=0 for 100 cycles during HOLD, while toggling `mode` and `level` → `out_valid` stays 1 and `ch`/`speed`/`y` are unchanged. Raising `out_ready` gives exactly one count increment.
- 1000 accepted spawns → no two consecutive `y` equal, every `y` a multiple of 9 and ≤ 621.
- `clrn` pulsed low in HOLD → all outputs return to their reset values the same cycle. `enable` dropped in WAIT → no spawn and state returns to IDLE.
